// File: rtl/memoria_principal_resp.sv
// Main-memory responder for the 2-way set-associative cache: 32 blocks,
// fixed access latency, level request / one-cycle ack handshake.
module memoria_principal_resp #(
  parameter int LATENCY = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 5,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ack,
  output logic              busy,
  output logic [CNT_W-1:0]  read_count,
  output logic [CNT_W-1:0]  write_count
);

  localparam int                 DEPTH    = 1 << ADDR_W;
  localparam int                 LAT_W    = 4;
  localparam logic [LAT_W-1:0]   LAT_LOAD = LAT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_RECOVER
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  state_e              state_q,       state_d;
  op_e                 op_q,          op_d;
  logic [LAT_W-1:0]    cnt_q,         cnt_d;
  logic [ADDR_W-1:0]   addr_q,        addr_d;
  logic [DATA_W-1:0]   wdata_q,       wdata_d;
  logic [DATA_W-1:0]   read_data_q,   read_data_d;
  logic                ack_q,         ack_d;
  logic [CNT_W-1:0]    read_count_q,  read_count_d;
  logic [CNT_W-1:0]    write_count_q, write_count_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    read_data_d   = read_data_q;
    ack_d         = 1'b0;
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    mem_d         = mem_q;

    unique case (state_q)
      S_IDLE: begin
        if (write_req || read_req) begin
          // Write-back wins over fill when both are pending.
          op_d    = write_req ? OP_WRITE : OP_READ;
          addr_d  = addr;
          wdata_d = write_data;
          cnt_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          ack_d   = 1'b1;
          if (op_q == OP_WRITE) begin
            mem_d[addr_q] = wdata_q;
            if (write_count_q != CNT_MAX) write_count_d = write_count_q + CNT_W'(1);
          end else begin
            read_data_d = mem_q[addr_q];
            if (read_count_q != CNT_MAX) read_count_d = read_count_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end

      // Requester gets one cycle to drop the served request before IDLE.
      S_DONE:    state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // sample their _d values from the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      op_q          <= OP_READ;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      read_data_q   <= '0;
      ack_q         <= 1'b0;
      read_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      read_data_q   <= read_data_d;
      ack_q         <= ack_d;
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
    end
  end

  // NOTE: the memory is deliberately reset (mem[i]=i), so it is built from
  // flops rather than a RAM macro; a RAM array would normally not be reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(i);
    end else begin
      mem_q <= mem_d;
    end
  end

  assign read_data   = read_data_q;
  assign ack         = ack_q;
  assign busy        = (state_q != S_IDLE);
  assign read_count  = read_count_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_memoria_principal_resp.sv
// Directed bench for memoria_principal_resp: one LATENCY=3 instance and one
// LATENCY=1 instance sharing clock and reset.
module tb_memoria_principal_resp;

  logic       clock;
  logic       reset_n;

  logic       read_req, write_req;
  logic [4:0] addr, write_data, read_data;
  logic       ack, busy;
  logic [7:0] read_count, write_count;

  logic       read_req1, write_req1;
  logic [4:0] addr1, write_data1, read_data1;
  logic       ack1, busy1;
  logic [7:0] read_count1, write_count1;

  int checks   = 0;
  int failures = 0;

  memoria_principal_resp #(.LATENCY(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .read_req(read_req), .write_req(write_req),
    .addr(addr), .write_data(write_data),
    .read_data(read_data), .ack(ack), .busy(busy),
    .read_count(read_count), .write_count(write_count)
  );

  memoria_principal_resp #(.LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .read_req(read_req1), .write_req(write_req1),
    .addr(addr1), .write_data(write_data1),
    .read_data(read_data1), .ack(ack1), .busy(busy1),
    .read_count(read_count1), .write_count(write_count1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL global_timeout simulation did not finish within 1ms");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Waits for ack on the LATENCY=3 instance; returns edges elapsed.
  task automatic wait_ack(input int budget, output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (edges < budget && !seen) begin
      step();
      edges++;
      if (ack === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic apply_reset;
    read_req = 0; write_req = 0; addr = 0; write_data = 0;
    read_req1 = 0; write_req1 = 0; addr1 = 0; write_data1 = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (read_data !== 5'd0) begin failures++; $display("FAIL reset_read_data got=%0d exp=0", read_data); end
    checks++; if (read_count !== 8'd0 || write_count !== 8'd0) begin
      failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", read_count, write_count);
    end
  endtask

  // Read addr 3: ack in the cycle after edge N+3, busy through RECOVER.
  task automatic test_read_basic;
    logic [3:0] exp_ack;
    exp_ack = 4'b1000;
    read_req = 1; addr = 5'b00011;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (ack !== exp_ack[k]) begin failures++; $display("FAIL read_ack_timing edge=N+%0d got=%b exp=%b", k, ack, exp_ack[k]); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL read_busy edge=N+%0d got=%b exp=1", k, busy); end
    end
    checks++; if (read_data !== 5'd3) begin failures++; $display("FAIL read_data_addr3 got=%0d exp=3", read_data); end
    checks++; if (read_count !== 8'd1) begin failures++; $display("FAIL read_count_1 got=%0d exp=1", read_count); end
    read_req = 0;
    step();
    checks++; if (ack !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL recover_state ack=%b busy=%b exp ack=0 busy=1", ack, busy); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_recover busy=%b exp=0", busy); end
  endtask

  task automatic test_write_then_read;
    int e; bit s;
    apply_reset();
    write_req = 1; addr = 5'd4; write_data = 5'b10101;
    wait_ack(20, e, s);
    checks++; if (!s || e != 4) begin failures++; $display("FAIL write_ack seen=%0d edges=%0d exp seen=1 edges=4", s, e); end
    checks++; if (write_count !== 8'd1) begin failures++; $display("FAIL write_count_1 got=%0d exp=1", write_count); end
    checks++; if (read_data !== 5'd0) begin failures++; $display("FAIL write_keeps_read_data got=%0d exp=0", read_data); end
    write_req = 0; write_data = 0;
    step(); step();
    read_req = 1; addr = 5'd4;
    wait_ack(20, e, s);
    checks++; if (!s) begin failures++; $display("FAIL read_after_write_timeout seen=0 exp=1"); end
    checks++; if (read_data !== 5'b10101) begin failures++; $display("FAIL read_after_write got=%0d exp=21", read_data); end
    read_req = 0;
    step(); step();
  endtask

  task automatic test_write_priority;
    int e; bit s;
    apply_reset();
    read_req = 1; write_req = 1; addr = 5'd2; write_data = 5'd7;
    wait_ack(20, e, s);
    checks++; if (!s) begin failures++; $display("FAIL prio_first_ack seen=0 exp=1"); end
    checks++; if (write_count !== 8'd1 || read_count !== 8'd0) begin
      failures++; $display("FAIL prio_write_first got w=%0d r=%0d exp w=1 r=0", write_count, read_count);
    end
    write_req = 0;
    wait_ack(20, e, s);
    checks++; if (!s || e != 6) begin failures++; $display("FAIL prio_read_ack seen=%0d edges=%0d exp seen=1 edges=6", s, e); end
    checks++; if (read_data !== 5'd7 || read_count !== 8'd1) begin
      failures++; $display("FAIL prio_read_data got d=%0d r=%0d exp d=7 r=1", read_data, read_count);
    end
    read_req = 0;
    step(); step();
  endtask

  task automatic test_reset_abort;
    int e; bit s; bit stray_ack;
    apply_reset();
    write_req = 1; addr = 5'd9; write_data = 5'd31;
    step(); step();
    checks++; if (busy !== 1'b1 || ack !== 1'b0) begin failures++; $display("FAIL abort_in_wait busy=%b ack=%b exp busy=1 ack=0", busy, ack); end
    write_req = 0; write_data = 0;
    reset_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0 || ack !== 1'b0) begin failures++; $display("FAIL abort_async busy=%b ack=%b exp 0/0", busy, ack); end
    step();
    reset_n = 1'b1;
    stray_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ack !== 1'b0) stray_ack = 1'b1;
    end
    checks++; if (stray_ack) begin failures++; $display("FAIL abort_no_ack got=ack exp=no ack"); end
    checks++; if (read_count !== 8'd0 || write_count !== 8'd0) begin
      failures++; $display("FAIL abort_counts got r=%0d w=%0d exp 0/0", read_count, write_count);
    end
    read_req = 1; addr = 5'd9;
    wait_ack(20, e, s);
    checks++; if (!s || read_data !== 5'd9) begin failures++; $display("FAIL abort_not_committed seen=%0d got=%0d exp=9", s, read_data); end
    read_req = 0;
    step(); step();
  endtask

  // read_req held high for 260 transactions; ack period is LATENCY+3 edges.
  task automatic test_back_to_back;
    int e; bit s;
    int pulse_bad, spacing_bad, data_bad, timeouts;
    apply_reset();
    pulse_bad = 0; spacing_bad = 0; data_bad = 0; timeouts = 0;
    read_req = 1;
    for (int i = 0; i < 260; i++) begin
      addr = 5'(i);
      wait_ack(20, e, s);
      if (!s) timeouts++;
      if (i > 0 && e + 1 != 6) spacing_bad++;
      if (read_data !== 5'(i)) data_bad++;
      if (i == 253) begin
        checks++; if (read_count !== 8'd254) begin failures++; $display("FAIL sat_count_254 got=%0d exp=254", read_count); end
      end
      if (i == 254) begin
        checks++; if (read_count !== 8'd255) begin failures++; $display("FAIL sat_count_255 got=%0d exp=255", read_count); end
      end
      step();
      if (ack !== 1'b0) pulse_bad++;
    end
    read_req = 0;
    step();
    checks++; if (timeouts != 0) begin failures++; $display("FAIL b2b_timeouts got=%0d exp=0", timeouts); end
    checks++; if (pulse_bad != 0) begin failures++; $display("FAIL b2b_single_pulse bad=%0d exp=0", pulse_bad); end
    checks++; if (spacing_bad != 0) begin failures++; $display("FAIL b2b_spacing bad=%0d exp=0", spacing_bad); end
    checks++; if (data_bad != 0) begin failures++; $display("FAIL b2b_read_data bad=%0d exp=0", data_bad); end
    checks++; if (read_count !== 8'd255) begin failures++; $display("FAIL sat_count_final got=%0d exp=255", read_count); end
  endtask

  task automatic test_latency1;
    apply_reset();
    read_req1 = 1; addr1 = 5'd31;
    step();
    checks++; if (ack1 !== 1'b0 || busy1 !== 1'b1) begin failures++; $display("FAIL lat1_accept ack=%b busy=%b exp 0/1", ack1, busy1); end
    addr1 = 5'd0;
    step();
    checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL lat1_ack got=%b exp=1", ack1); end
    checks++; if (read_data1 !== 5'd31) begin failures++; $display("FAIL lat1_latched_addr got=%0d exp=31", read_data1); end
    read_req1 = 0;
    step();
    checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL lat1_single_pulse got=%b exp=0", ack1); end
    step();
    checks++; if (busy1 !== 1'b0 || read_count1 !== 8'd1) begin
      failures++; $display("FAIL lat1_idle busy=%b count=%0d exp 0/1", busy1, read_count1);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_then_read();
    test_write_priority();
    test_reset_abort();
    test_back_to_back();
    test_latency1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
